// File: rtl/booth_mult.sv
// Multicycle signed multiplier using radix-4 modified Booth recoding: one 3-bit digit per clock.
// Result and overflow flag are registered on completion and held until the next operation finishes.
module booth_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] mult_result,
    output logic             mult_exception,
    output logic             mult_resultrdy,
    output logic             mult_busy,
    output logic [1:0]       dbg_state
);

    localparam int AW = WIDTH + 2;
    localparam int PW = 2 * WIDTH + 3;
    localparam int CW = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH / 2 - 1);

    // Handshake: enable is a single-cycle start pulse, accepted only in IDLE or DONE;
    // mult_resultrdy is high for exactly the DONE cycle and is not back-pressured.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [AW-1:0]    m_q;
    logic [PW-1:0]    p_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;
    logic             rdy_q;

    logic [AW-1:0]      term;
    logic               neg;
    logic [AW-1:0]      upper_sum;
    logic [PW-1:0]      p_d;
    logic [2*WIDTH-1:0] prod;
    logic               exc_d;

    always_comb begin
        term = '0;
        neg  = 1'b0;
        case (p_q[2:0])
            3'b001, 3'b010: term = m_q;
            3'b011:         term = {m_q[AW-2:0], 1'b0};
            3'b100: begin
                term = ~{m_q[AW-2:0], 1'b0};
                neg  = 1'b1;
            end
            3'b101, 3'b110: begin
                term = ~m_q;
                neg  = 1'b1;
            end
            default: term = '0;
        endcase
        // Subtraction is ~X plus a carry-in of one; the arithmetic shift reuses the sum's sign.
        upper_sum = p_q[PW-1:WIDTH+1] + term + {{(AW-1){1'b0}}, neg};
        p_d       = {{2{upper_sum[AW-1]}}, upper_sum, p_q[WIDTH:2]};
        prod      = p_d[2*WIDTH:1];
        exc_d     = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            m_q      <= '0;
            p_q      <= '0;
            count_q  <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    rdy_q <= 1'b0;
                    if (enable) begin
                        state_q <= RUN;
                        m_q     <= {{2{data_operandA[WIDTH-1]}}, data_operandA};
                        p_q     <= {{AW{1'b0}}, data_operandB, 1'b0};
                        count_q <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    p_q     <= p_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == LAST) begin
                        state_q  <= DONE;
                        result_q <= prod[WIDTH-1:0];
                        exc_q    <= exc_d;
                        rdy_q    <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mult_result    = result_q;
    assign mult_exception = exc_q;
    assign mult_resultrdy = rdy_q;
    assign mult_busy      = (state_q == RUN);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_booth_mult.sv
// Self-checking bench for booth_mult: directed corner products, random operands against
// a 64-bit arithmetic reference, start-while-busy, back-to-back and mid-run reset.
module tb_booth_mult;
  localparam int W     = 32;
  localparam int STEPS = W / 2;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic         clock = 1'b0;
  logic         clear_n = 1'b0;
  logic         enable = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic [W-1:0] mult_result;
  logic         mult_exception;
  logic         mult_resultrdy;
  logic         mult_busy;
  logic [1:0]   dbg_state;

  logic [W-1:0] exp_q[$];
  logic         exp_exc_q[$];
  int n_pass  = 0;
  int n_total = 0;

  booth_mult #(.WIDTH(W)) dut (
    .clock          (clock),
    .clear_n        (clear_n),
    .enable         (enable),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .mult_result    (mult_result),
    .mult_exception (mult_exception),
    .mult_resultrdy (mult_resultrdy),
    .mult_busy      (mult_busy),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // reference: full signed product in 64 bits, overflow when outside the 32-bit signed range
  task automatic model_push(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    exp_q.push_back(p[W-1:0]);
    exp_exc_q.push_back((p > MAXV) || (p < MINV));
  endtask

  // driver: one-cycle enable pulse, returns at the negedge after the sampling edge
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clock);
    op_a   = x;
    op_b   = y;
    enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
  endtask

  // waits for resultrdy; edges = posedges from the current negedge until it is seen
  task automatic wait_rdy(output int edges, output int busy_cycles, output bit ok);
    edges       = 0;
    busy_cycles = mult_busy ? 1 : 0;
    ok          = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      @(negedge clock);
      edges++;
      if (mult_resultrdy) begin
        ok = 1'b1;
        break;
      end
      if (mult_busy) busy_cycles++;
    end
  endtask

  task automatic test_reset;
    clear_n = 1'b0;
    repeat (3) @(negedge clock);
    n_total++;
    if ({mult_result, mult_exception, mult_resultrdy, mult_busy, dbg_state} !== '0)
      $display("FAIL reset_hold: result=%h exc=%b rdy=%b busy=%b state=%0d, required all 0",
               mult_result, mult_exception, mult_resultrdy, mult_busy, dbg_state);
    else n_pass++;
    clear_n = 1'b1;
    repeat (2) @(negedge clock);
    n_total++;
    if ({mult_result, mult_exception, mult_resultrdy, mult_busy, dbg_state} !== '0)
      $display("FAIL reset_idle: result=%h exc=%b rdy=%b busy=%b, required all 0",
               mult_result, mult_exception, mult_resultrdy, mult_busy);
    else n_pass++;
  endtask

  logic [W-1:0] dir_a[8]   = '{32'd7, 32'hFFFFFFFD, 32'hFFFFFFFC, 32'h7FFFFFFF,
                               32'h80000000, 32'h00010000, 32'h80000000, 32'd0};
  logic [W-1:0] dir_b[8]   = '{32'd6, 32'd5, 32'hFFFFFFF8, 32'd2,
                               32'hFFFFFFFF, 32'h00010000, 32'd1, 32'h80000000};
  logic [W-1:0] dir_res[8] = '{32'd42, 32'hFFFFFFF1, 32'd32, 32'hFFFFFFFE,
                               32'h80000000, 32'd0, 32'h80000000, 32'd0};
  logic         dir_exc[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  task automatic test_directed;
    int edges, busy_cycles;
    bit ok;
    for (int i = 0; i < 8; i++) begin
      start_op(dir_a[i], dir_b[i]);
      wait_rdy(edges, busy_cycles, ok);
      n_total++;
      if (!ok || edges != STEPS)
        $display("FAIL dir%0d_latency: ok=%b edges=%0d, required edges=%0d", i, ok, edges, STEPS);
      else n_pass++;
      n_total++;
      if (busy_cycles != STEPS)
        $display("FAIL dir%0d_busy: busy cycles=%0d, required %0d", i, busy_cycles, STEPS);
      else n_pass++;
      n_total++;
      if (mult_result !== dir_res[i] || mult_exception !== dir_exc[i])
        $display("FAIL dir%0d_value: got %h exc=%b, required %h exc=%b",
                 i, mult_result, mult_exception, dir_res[i], dir_exc[i]);
      else n_pass++;
      @(posedge clock);
      @(negedge clock);
      n_total++;
      if (mult_resultrdy !== 1'b0 || mult_busy !== 1'b0 || mult_result !== dir_res[i])
        $display("FAIL dir%0d_pulse_hold: rdy=%b busy=%b result=%h, required 0 0 %h",
                 i, mult_resultrdy, mult_busy, mult_result, dir_res[i]);
      else n_pass++;
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h80000000;
      1: return 32'h7FFFFFFF;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 300));
      4: return 32'(-$urandom_range(0, 300));
      5: return 32'($urandom_range(0, 65535));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random;
    int edges, busy_cycles;
    bit ok;
    logic [W-1:0] x, y, e;
    logic ee;
    for (int i = 0; i < 40; i++) begin
      x = pick_operand();
      y = pick_operand();
      model_push(x, y);
      start_op(x, y);
      wait_rdy(edges, busy_cycles, ok);
      e  = exp_q.pop_front();
      ee = exp_exc_q.pop_front();
      n_total++;
      if (!ok || edges != STEPS)
        $display("FAIL rand%0d_latency: ok=%b edges=%0d, required %0d", i, ok, edges, STEPS);
      else n_pass++;
      n_total++;
      if (mult_result !== e || mult_exception !== ee)
        $display("FAIL rand%0d_value: a=%h b=%h got %h exc=%b, required %h exc=%b",
                 i, x, y, mult_result, mult_exception, e, ee);
      else n_pass++;
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
  endtask

  task automatic test_enable_during_run;
    int edges, busy_cycles, extra_rdy;
    bit ok;
    logic [W-1:0] e;
    logic ee;
    model_push(32'd123456, 32'hFFFFFCEB);
    start_op(32'd123456, 32'hFFFFFCEB);
    repeat (4) @(negedge clock);
    op_a   = $urandom;
    op_b   = $urandom;
    enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    wait_rdy(edges, busy_cycles, ok);
    e  = exp_q.pop_front();
    ee = exp_exc_q.pop_front();
    n_total++;
    if (!ok || edges != STEPS - 5)
      $display("FAIL busy_start_latency: ok=%b edges=%0d, required %0d", ok, edges, STEPS - 5);
    else n_pass++;
    n_total++;
    if (mult_result !== e || mult_exception !== ee)
      $display("FAIL busy_start_value: got %h exc=%b, required %h exc=%b",
               mult_result, mult_exception, e, ee);
    else n_pass++;
    extra_rdy = 0;
    repeat (20) begin
      @(negedge clock);
      if (mult_resultrdy || mult_busy) extra_rdy++;
    end
    n_total++;
    if (extra_rdy != 0)
      $display("FAIL busy_start_no_second_op: active cycles=%0d, required 0", extra_rdy);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int edges, busy_cycles;
    bit ok;
    logic [W-1:0] e1, e2, x, y;
    logic ee1, ee2;
    model_push(32'hFFFF1234, 32'd999);
    start_op(32'hFFFF1234, 32'd999);
    wait_rdy(edges, busy_cycles, ok);
    e1  = exp_q.pop_front();
    ee1 = exp_exc_q.pop_front();
    n_total++;
    if (!ok || mult_result !== e1 || mult_exception !== ee1)
      $display("FAIL b2b_first: ok=%b got %h exc=%b, required %h exc=%b",
               ok, mult_result, mult_exception, e1, ee1);
    else n_pass++;
    x = $urandom;
    y = $urandom;
    model_push(x, y);
    op_a   = x;
    op_b   = y;
    enable = 1'b1;
    @(posedge clock);
    @(negedge clock);
    enable = 1'b0;
    n_total++;
    if (mult_busy !== 1'b1 || mult_resultrdy !== 1'b0 || mult_result !== e1)
      $display("FAIL b2b_no_gap: busy=%b rdy=%b result=%h, required 1 0 %h",
               mult_busy, mult_resultrdy, mult_result, e1);
    else n_pass++;
    wait_rdy(edges, busy_cycles, ok);
    e2  = exp_q.pop_front();
    ee2 = exp_exc_q.pop_front();
    n_total++;
    if (!ok || edges != STEPS)
      $display("FAIL b2b_latency: ok=%b edges=%0d, required %0d", ok, edges, STEPS);
    else n_pass++;
    n_total++;
    if (mult_result !== e2 || mult_exception !== ee2)
      $display("FAIL b2b_second: got %h exc=%b, required %h exc=%b",
               mult_result, mult_exception, e2, ee2);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run;
    int edges, busy_cycles, stray;
    bit ok;
    logic [W-1:0] e;
    logic ee;
    start_op(32'h7FFFFFFF, 32'h7FFFFFFF);
    repeat (7) @(negedge clock);
    #2 clear_n = 1'b0;
    #1;
    n_total++;
    if ({mult_result, mult_exception, mult_resultrdy, mult_busy, dbg_state} !== '0)
      $display("FAIL midrun_reset: result=%h exc=%b rdy=%b busy=%b state=%0d, required all 0",
               mult_result, mult_exception, mult_resultrdy, mult_busy, dbg_state);
    else n_pass++;
    repeat (2) @(negedge clock);
    clear_n = 1'b1;
    stray = 0;
    repeat (25) begin
      @(negedge clock);
      if (mult_resultrdy || mult_busy) stray++;
    end
    n_total++;
    if (stray != 0)
      $display("FAIL midrun_no_ready: active cycles=%0d, required 0", stray);
    else n_pass++;
    model_push(32'hFFFFF000, 32'h00001234);
    start_op(32'hFFFFF000, 32'h00001234);
    wait_rdy(edges, busy_cycles, ok);
    e  = exp_q.pop_front();
    ee = exp_exc_q.pop_front();
    n_total++;
    if (!ok || edges != STEPS || mult_result !== e || mult_exception !== ee)
      $display("FAIL midrun_restart: ok=%b edges=%0d got %h exc=%b, required edges=%0d %h exc=%b",
               ok, edges, mult_result, mult_exception, STEPS, e, ee);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_enable_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
